// File: rtl/meas_tx_if.sv
// Bundle of the meas_tx request, measurement-buffer read and FT245 write-FIFO signals.
// master = frame transmitter side, slave = host/buffer/FIFO side.
interface meas_tx_if;
    logic       start;
    logic       abort;
    logic [3:0] op_mode;
    logic [6:0] meas_addr;
    logic [7:0] meas_byte;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_full;
    logic       busy;
    logic       done;

    modport master (
        input  start, abort, op_mode, meas_byte, wr_full,
        output meas_addr, wr_en, wr_data, busy, done
    );

    modport slave (
        output start, abort, op_mode, meas_byte, wr_full,
        input  meas_addr, wr_en, wr_data, busy, done
    );
endinterface

// File: rtl/meas_tx.sv
// meas_tx: streams one measurement frame (SOF, TYPE, LEN, payload) into an FT245 write FIFO.
// Defining MEAS_TX_CHECKSUM_EN appends an XOR checksum byte over TYPE, LEN and payload.
module meas_tx #(
    parameter int         PAYLOAD_LEN = 98,
    parameter logic [7:0] SOF_BYTE    = 8'hA5
) (
    input  logic      clk,
    input  logic      reset,
    meas_tx_if.master bus
);
    // state   | meaning
    // IDLE    | waiting for start        SOF/TYPE/LEN | header byte pending
    // PAYLOAD | buffer byte idx pending  CSUM         | checksum byte pending
    // DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_TYPE,
        ST_LEN,
        ST_PAYLOAD,
`ifdef MEAS_TX_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE
    } state_t;

    localparam logic [7:0] LEN_BYTE = 8'(PAYLOAD_LEN);
    localparam logic [6:0] LAST_IDX = 7'(PAYLOAD_LEN - 1);

    state_t     state;
    state_t     state_nx;
    logic [6:0] idx;
    logic [3:0] mode_q;
    logic       byte_state;
    logic       wr_go;
    logic [7:0] wr_byte;

    assign byte_state = (state != ST_IDLE) && (state != ST_DONE);
    // A pending byte leaves only when the FIFO has room and the frame is not being aborted.
    assign wr_go      = byte_state && !bus.wr_full && !bus.abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            mode_q <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && bus.start)
                mode_q <= bus.op_mode;
            if (state == ST_IDLE || bus.abort)
                idx <= '0;
            else if (state == ST_PAYLOAD && wr_go)
                idx <= idx + 7'd1;
        end
    end

`ifdef MEAS_TX_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            csum <= '0;
        else if (state == ST_IDLE)
            csum <= '0;
        else if (wr_go && (state == ST_TYPE || state == ST_LEN || state == ST_PAYLOAD))
            csum <= csum ^ wr_byte;
    end
`endif

    always_comb begin
        state_nx = state;
        wr_byte  = 8'h00;
        case (state)
            ST_IDLE: begin
                if (bus.start)
                    state_nx = ST_SOF;
            end
            ST_SOF: begin
                wr_byte = SOF_BYTE;
                if (wr_go)
                    state_nx = ST_TYPE;
            end
            ST_TYPE: begin
                wr_byte = {4'h1, mode_q};
                if (wr_go)
                    state_nx = ST_LEN;
            end
            ST_LEN: begin
                wr_byte = LEN_BYTE;
                if (wr_go)
                    state_nx = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                wr_byte = bus.meas_byte;
                if (wr_go && idx == LAST_IDX)
`ifdef MEAS_TX_CHECKSUM_EN
                    state_nx = ST_CSUM;
`else
                    state_nx = ST_DONE;
`endif
            end
`ifdef MEAS_TX_CHECKSUM_EN
            ST_CSUM: begin
                wr_byte = csum;
                if (wr_go)
                    state_nx = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        if (bus.abort)
            state_nx = ST_IDLE;
    end

    assign bus.wr_en     = wr_go;
    assign bus.wr_data   = wr_go ? wr_byte : 8'h00;
    assign bus.meas_addr = (state == ST_PAYLOAD) ? idx : 7'd0;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
endmodule

// File: tb/tb_meas_tx.sv
// Bench for meas_tx: scoreboard of expected frame bytes, popped on every wr_en.
// Buffer model: meas_byte = {0, meas_addr} ^ pat.
module tb_meas_tx;
    localparam int PL = 98;
`ifdef MEAS_TX_CHECKSUM_EN
    localparam int CSB = 1;
`else
    localparam int CSB = 0;
`endif
    localparam int NB = PL + 3 + CSB;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pat   = 8'h00;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         c0    = 0;
    int         exp_done = -1;
    bit         done_seen = 1'b0;
    bit         first_pend = 1'b0;
    logic [7:0] exp_q[$];

    meas_tx_if bus();

    meas_tx #(.PAYLOAD_LEN(PL), .SOF_BYTE(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.meas_byte = {1'b0, bus.meas_addr} ^ pat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.wr_en) begin
                chk("unexpected_byte", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0)
                    chk("wr_data", bus.wr_data, exp_q.pop_front());
                if (first_pend) begin
                    chk("sof_latency", cyc - c0, 1);
                    first_pend = 1'b0;
                end
            end
            if (bus.done) begin
                chk("done_cycle", cyc - c0, exp_done);
                done_seen = 1'b1;
            end
        end
    end

    task automatic kick(input logic [3:0] mode, input logic [7:0] p, input int done_rel);
        logic [7:0] t;
        pat = p;
        t   = {4'h1, mode};
        exp_q.push_back(8'hA5);
        exp_q.push_back(t);
        exp_q.push_back(8'(PL));
        for (int i = 0; i < PL; i++)
            exp_q.push_back(8'(i) ^ p);
`ifdef MEAS_TX_CHECKSUM_EN
        begin
            logic [7:0] cs;
            cs = 8'h00;
            for (int i = 1; i < exp_q.size(); i++)
                cs ^= exp_q[i];
            exp_q.push_back(cs);
        end
`endif
        bus.op_mode = mode;
        bus.start   = 1'b1;
        c0          = cyc;
        exp_done    = done_rel;
        done_seen   = 1'b0;
        first_pend  = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.op_mode = ~mode;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done_seen && k < 1000) begin
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done_seen), 1);
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_addr(input logic [6:0] a, input string tag);
        int k;
        k = 0;
        while (bus.meas_addr !== a && k < 300) begin
            tick();
            k++;
        end
        chk(tag, 32'(bus.meas_addr), 32'(a));
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.op_mode = 4'h0;
        bus.wr_full = 1'b0;
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_meas_addr", bus.meas_addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        reset = 1'b0;
        tick();

        kick(4'h7, 8'h00, NB + 1);
        chk("busy_in_frame", bus.busy, 1);
        wait_done("basic");
        chk("busy_after", bus.busy, 0);

        // second start mid-frame must be dropped; monitor flags any extra byte
        kick(4'hC, 8'h5A, NB + 1);
        repeat (20) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("restart_ignored");
        repeat (10) tick();

        kick(4'h3, 8'h00, NB + 1 + 5);
        wait_addr(7'd10, "reach_idx10");
        bus.wr_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_wr_en", bus.wr_en, 0);
            chk("stall_addr", bus.meas_addr, 10);
            tick();
        end
        bus.wr_full = 1'b0;
        wait_done("stall");

        kick(4'h9, 8'h33, -1);
        wait_addr(7'd40, "reach_idx40");
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_wr_en", bus.wr_en, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_remaining", exp_q.size(), PL - 40 + CSB);
        exp_q.delete();
        repeat (10) tick();
        kick(4'h2, 8'hF0, NB + 1);
        wait_done("after_abort");

        kick(4'h5, 8'h00, -1);
        tick();
        tick();
        chk("pre_reset_len", bus.wr_data, PL);
        #2 reset = 1'b1;
        #1;
        chk("arst_wr_en", bus.wr_en, 0);
        chk("arst_wr_data", bus.wr_data, 0);
        chk("arst_meas_addr", bus.meas_addr, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        kick(4'h6, 8'h11, NB + 1);
        wait_done("after_reset");
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/meas_tx.md
MEAS_TX -- requirements
Module: meas_tx

Interface
REQ-001 SHALL have parameter PAYLOAD_LEN, default 98, payload bytes per frame (legal range 1..127).
REQ-002 SHALL have parameter SOF_BYTE, default 8'hA5, start-of-frame marker.
REQ-003 clk  input  1  single clock; all logic on posedge clk; one clock only, reset asynchronous and active-high.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 start  input  1  one-cycle request to send one measurement frame.
REQ-006 abort  input  1  synchronous frame abort.
REQ-007 op_mode  input  4  current controlstate, sampled at frame start.
REQ-008 meas_addr  output  7  payload byte index into measurement buffer.
REQ-009 meas_byte  input  8  buffer byte at meas_addr, combinational, same cycle.
REQ-010 wr_en  output  1  write strobe to FT245 write FIFO.
REQ-011 wr_data  output  8  byte written when wr_en high.
REQ-012 wr_full  input  1  FT245 write FIFO full.
REQ-013 busy  output  1  high from accepted start until done.
REQ-014 done  output  1  one-cycle pulse after final byte written.

Function
REQ-015 SHALL emit frame bytes in order: SOF_BYTE, TYPE={4'h1,op_mode latched}, LEN=PAYLOAD_LEN[7:0], payload[0..PAYLOAD_LEN-1], then CSUM (see Configuration).
REQ-016 SHALL implement states IDLE, SOF, TYPE, LEN, PAYLOAD, CSUM, DONE; IDLE->SOF on start; each byte state advances only on a cycle where its byte is written; PAYLOAD->CSUM (or DONE) after index PAYLOAD_LEN-1; DONE->IDLE after one cycle.
REQ-017 SHALL assert wr_en only when wr_full is low in a byte state; wr_data registered with wr_en, exactly one byte per wr_en cycle, no byte lost or repeated.
REQ-018 SHALL hold the pending byte and index unchanged while wr_full is high, for any number of cycles.
REQ-019 SHALL latch start in IDLE only; start while busy is ignored (no queuing).
REQ-020 SHALL drive meas_addr = current payload index, 0 outside PAYLOAD; meas_byte sampled in the same cycle the byte is written.
REQ-021 Latency: start sampled in cycle 0 -> first wr_en (SOF) in cycle 1 when wr_full low; back-to-back bytes every cycle thereafter.
REQ-022 CSUM SHALL be 8-bit XOR of TYPE, LEN and all payload bytes; SOF excluded.
REQ-023 abort SHALL force IDLE next cycle, wr_en low, busy low, no done pulse; abort has priority over start in the same cycle.
REQ-024 SHALL keep busy high in SOF..DONE, low in IDLE; done high only in DONE.

Reset
REQ-025 On reset: state IDLE, wr_en 0, wr_data 8'h00, meas_addr 0, busy 0, done 0, checksum and index cleared.
REQ-026 Reset mid-frame SHALL truncate the frame immediately; the next start sends a complete new frame from SOF.

Configuration
REQ-027 Macro MEAS_TX_CHECKSUM_EN defined: CSUM state present, frame = PAYLOAD_LEN+4 bytes.
REQ-028 MEAS_TX_CHECKSUM_EN undefined: CSUM state and XOR logic absent, PAYLOAD->DONE directly, frame = PAYLOAD_LEN+3 bytes; LEN field unchanged.

Verification
REQ-029 Checksum enabled, PAYLOAD_LEN=98, meas_byte=meas_addr, op_mode=4'h7, wr_full=0, start at cycle 0 -> 102 wr_en cycles 1..102: A5,17,62,00..61,74; done cycle 103.
REQ-030 Same, checksum disabled -> 101 bytes A5,17,62,00..61; done cycle 102; no 74 byte.
REQ-031 wr_full high 5 cycles while payload index 10 pending -> no wr_en for 5 cycles, then byte 0x0A written once, stream continues 0x0B.
REQ-032 abort in PAYLOAD at index 40 -> wr_en low next cycle, busy 0, done never pulses; next start yields full correct frame.
REQ-033 start pulsed again during frame -> ignored, exactly one frame emitted; reset asserted mid-LEN -> all outputs at reset values asynchronously.
